stress_sensor_sequencer: RTL and testbench

//  Measurement sequencer for the stress-sensor ring-oscillator bank. One edge counter is

---
 rtl/stress_sensor_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_stress_sensor_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stress_sensor_sequencer.sv
// Round-robin ring-oscillator measurement sequencer: settle, count edges over a window, report, compare.
// Optional macro STRESS_SENSOR_ALARM_LATCH_EN makes alarm_flags sticky and adds clear_alarm.
module stress_sensor_sequencer #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 12,
  parameter int SETTLE_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic                       start,
  input  logic                       continuous,
  input  logic [NUM_CH-1:0]          ch_mask,
  input  logic [WIN_W-1:0]           window_len,
  input  logic [CNT_W-1:0]           thresh,
  input  logic [NUM_CH-1:0]          osc_in,
`ifdef STRESS_SENSOR_ALARM_LATCH_EN
  input  logic                       clear_alarm,
`endif
  output logic [NUM_CH-1:0]          osc_en,
  output logic                       busy,
  output logic [CNT_W-1:0]           result,
  output logic [$clog2(NUM_CH)-1:0]  result_ch,
  output logic                       result_valid,
  output logic [NUM_CH-1:0]          alarm_flags,
  output logic                       alarm
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > SET_W) ? WIN_W : SET_W;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_SETTLE,
    S_COUNT,
    S_REPORT
  } state_t;

  state_t            state, state_nxt;
  logic              load_sweep;
  logic [NUM_CH-1:0] mask_q;
  logic [WIN_W-1:0]  win_q;
  logic [CNT_W-1:0]  thresh_q;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   first_ch, next_ch;
  logic              first_found, next_found;
  logic [TMR_W-1:0]  timer, win_last;
  logic              timer_done;
  logic [CNT_W-1:0]  count, count_nxt;
  logic              sync1, sync2, prev;
  logic              edge_seen, report_now, below;
  logic [NUM_CH-1:0] ch_onehot;

  // Lowest channel in the incoming mask, and the next channel above cur_ch in the latched mask.
  always_comb begin
    first_ch    = '0;
    first_found = 1'b0;
    next_ch     = '0;
    next_found  = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        first_ch    = CH_W'(i);
        first_found = 1'b1;
      end
      if (mask_q[i] && (i > int'(cur_ch))) begin
        next_ch    = CH_W'(i);
        next_found = 1'b1;
      end
    end
  end

  assign timer_done = (timer == '0);
  assign win_last   = (win_q == '0) ? '0 : TMR_W'(win_q) - TMR_W'(1);
  assign edge_seen  = sync2 & ~prev;
  assign count_nxt  = (edge_seen && (count != CNT_MAX)) ? count + CNT_W'(1) : count;
  assign report_now = (state == S_COUNT) && timer_done && ena;
  assign below      = (count_nxt < thresh_q);
  assign ch_onehot  = NUM_CH'(1) << cur_ch;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    load_sweep = 1'b0;
    case (state)
      S_IDLE: begin
        if (ena && start && first_found) begin
          state_nxt  = S_SELECT;
          load_sweep = 1'b1;
        end
      end
      S_SELECT: state_nxt = S_SETTLE;
      S_SETTLE: if (timer_done) state_nxt = S_COUNT;
      S_COUNT:  if (timer_done) state_nxt = S_REPORT;
      S_REPORT: begin
        if (next_found) begin
          state_nxt = S_SELECT;
        end else if (continuous && first_found) begin
          state_nxt  = S_SELECT;
          load_sweep = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (!ena) begin
      state_nxt  = S_IDLE;
      load_sweep = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      win_q     <= '0;
      thresh_q  <= '0;
      cur_ch    <= '0;
      timer     <= '0;
      count     <= '0;
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      prev      <= 1'b0;
      result    <= '0;
      result_ch <= '0;
    end else begin
      if (load_sweep) begin
        mask_q   <= ch_mask;
        win_q    <= window_len;
        thresh_q <= thresh;
        cur_ch   <= first_ch;
      end else if (state_nxt == S_SELECT) begin
        cur_ch <= next_ch;
      end

      // Single synchroniser shared by all channels; flushed whenever a new channel is selected.
      if (state == S_SELECT) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
        prev  <= 1'b0;
      end else begin
        sync1 <= osc_in[cur_ch];
        sync2 <= sync1;
        prev  <= sync2;
      end

      case (state)
        S_SELECT: begin
          timer <= SETTLE_LAST;
          count <= '0;
        end
        S_SETTLE: timer <= timer_done ? win_last : timer - TMR_W'(1);
        S_COUNT: begin
          count <= count_nxt;
          if (!timer_done) timer <= timer - TMR_W'(1);
        end
        default: ;
      endcase

      if (report_now) begin
        result    <= count_nxt;
        result_ch <= cur_ch;
      end
    end
  end

`ifdef STRESS_SENSOR_ALARM_LATCH_EN
  // Sticky flags: a compare hit in the same cycle as clear_alarm survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_flags <= '0;
    else alarm_flags <= (clear_alarm ? '0 : alarm_flags)
                      | ((report_now && below) ? ch_onehot : '0);
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          alarm_flags         <= '0;
    else if (report_now) alarm_flags[cur_ch] <= below;
  end
`endif

  assign osc_en       = ((state == S_SELECT) || (state == S_SETTLE) || (state == S_COUNT))
                        ? ch_onehot : '0;
  assign busy         = (state != S_IDLE);
  assign result_valid = (state == S_REPORT);
  assign alarm        = |alarm_flags;

endmodule

// File: tb/tb_stress_sensor_sequencer.sv
// Directed bench for stress_sensor_sequencer: sweep order/latency, idle guard, continuous mode,
// abort and reset, window edge cases, saturation (CNT_W=4 copy) and alarm flag behaviour.
module tb_stress_sensor_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena, start, continuous;
  logic [3:0]  ch_mask;
  logic [11:0] window_len;
  logic [15:0] thresh;
  logic [3:0]  thresh_s;
  logic [3:0]  osc_in = '0;
`ifdef STRESS_SENSOR_ALARM_LATCH_EN
  logic        clear_alarm = 1'b0;
`endif

  logic [3:0]  osc_en, alarm_flags;
  logic        busy, result_valid, alarm;
  logic [15:0] result;
  logic [1:0]  result_ch;

  logic [3:0]  osc_en_s, alarm_flags_s, result_s;
  logic        busy_s, result_valid_s, alarm_s;
  logic [1:0]  result_ch_s;

  int total = 0;
  int bad   = 0;
  int per[4] = '{0, 0, 0, 0};
  int cyc = 0;

  stress_sensor_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .window_len(window_len), .thresh(thresh), .osc_in(osc_in),
`ifdef STRESS_SENSOR_ALARM_LATCH_EN
    .clear_alarm(clear_alarm),
`endif
    .osc_en(osc_en), .busy(busy), .result(result), .result_ch(result_ch),
    .result_valid(result_valid), .alarm_flags(alarm_flags), .alarm(alarm)
  );

  stress_sensor_sequencer #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .continuous(continuous),
    .ch_mask(ch_mask), .window_len(window_len), .thresh(thresh_s), .osc_in(osc_in),
`ifdef STRESS_SENSOR_ALARM_LATCH_EN
    .clear_alarm(clear_alarm),
`endif
    .osc_en(osc_en_s), .busy(busy_s), .result(result_s), .result_ch(result_ch_s),
    .result_valid(result_valid_s), .alarm_flags(alarm_flags_s), .alarm(alarm_s)
  );

  always #5 clk = ~clk;

  // Square-wave oscillators, period per[i] clk cycles (0 = held low), changing on the falling edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 4; i++) osc_in[i] = (per[i] != 0) && ((cyc % per[i]) < (per[i] / 2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [3:0] m, input logic [11:0] w, input logic [15:0] th);
    ch_mask    = m;
    window_len = w;
    thresh     = th;
    thresh_s   = th[3:0];
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_rv(input int limit, output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < limit) begin
      tick();
      n++;
      seen = result_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %0b want 0", busy); end
    total++; if (osc_en !== 4'h0) begin bad++; $display("FAIL reset_osc_en: got %0h want 0", osc_en); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_rv: got %0b want 0", result_valid); end
    total++; if (result !== 16'h0) begin bad++; $display("FAIL reset_result: got %0h want 0", result); end
    total++; if (alarm_flags !== 4'h0 || alarm !== 1'b0) begin
      bad++; $display("FAIL reset_alarm: got flags=%0h alarm=%0b want 0/0", alarm_flags, alarm);
    end
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();
  endtask

  task automatic test_sweep();
    int rv_t[$];
    logic [15:0] rv_res[$];
    logic [1:0]  rv_ch[$];
    per[0] = 4; per[2] = 8;
    start_sweep(4'b0101, 12'd16, 16'd5);
    total++; if (osc_en !== 4'b0001 || busy !== 1'b1) begin
      bad++; $display("FAIL sweep_select: got osc_en=%0h busy=%0b want 1/1", osc_en, busy);
    end
    for (int t = 2; t <= 60; t++) begin
      tick();
      if (result_valid) begin rv_t.push_back(t); rv_res.push_back(result); rv_ch.push_back(result_ch); end
      if (t == 26) begin
        total++; if (osc_en !== 4'h0) begin bad++; $display("FAIL sweep_report_osc: got %0h want 0", osc_en); end
      end
      if (t == 27) begin
        total++; if (osc_en !== 4'b0100) begin bad++; $display("FAIL sweep_ch2_osc: got %0h want 4", osc_en); end
      end
      if (t == 52) begin
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL sweep_busy_report: got %0b want 1", busy); end
      end
      if (t == 53) begin
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL sweep_busy_end: got %0b want 0", busy); end
      end
    end
    total++;
    if (rv_t.size() != 2) begin
      bad++; $display("FAIL sweep_pulses: got %0d want 2", rv_t.size());
    end else begin
      if (rv_t[0] != 26 || rv_t[1] != 52) begin
        bad++; $display("FAIL sweep_latency: got %0d,%0d want 26,52", rv_t[0], rv_t[1]);
      end
      total++; if (rv_ch[0] !== 2'd0 || rv_ch[1] !== 2'd2) begin
        bad++; $display("FAIL sweep_order: got %0d,%0d want 0,2", rv_ch[0], rv_ch[1]);
      end
      total++; if (!(rv_res[0] >= 3 && rv_res[0] <= 5)) begin
        bad++; $display("FAIL sweep_count_ch0: got %0d want 3..5", rv_res[0]);
      end
      total++; if (!(rv_res[1] >= 1 && rv_res[1] <= 3)) begin
        bad++; $display("FAIL sweep_count_ch2: got %0d want 1..3", rv_res[1]);
      end
    end
    total++; if (alarm_flags !== 4'b0101 || alarm !== 1'b1) begin
      bad++; $display("FAIL sweep_alarm: got flags=%0h alarm=%0b want 5/1", alarm_flags, alarm);
    end
    per[0] = 0; per[2] = 0;
  endtask

  task automatic test_mask_zero();
    ch_mask = 4'h0;
    start   = 1'b1;
    repeat (3) tick();
    total++; if (busy !== 1'b0 || osc_en !== 4'h0) begin
      bad++; $display("FAIL mask0_idle: got busy=%0b osc_en=%0h want 0/0", busy, osc_en);
    end
    start = 1'b0;
    tick();
  endtask

  task automatic test_continuous();
    int rv_t[$];
    bit ch_ok = 1'b1;
    continuous = 1'b1;
    start_sweep(4'b1000, 12'd4, 16'd0);
    for (int t = 2; t <= 70; t++) begin
      tick();
      if (result_valid) begin
        rv_t.push_back(t);
        if (result_ch !== 2'd3 || result !== 16'd0) ch_ok = 1'b0;
      end
      if (t == 30) continuous = 1'b0;
    end
    total++;
    if (rv_t.size() != 3) begin
      bad++; $display("FAIL cont_pulses: got %0d want 3", rv_t.size());
    end else if (rv_t[0] != 14 || rv_t[1] != 28 || rv_t[2] != 42) begin
      bad++; $display("FAIL cont_period: got %0d,%0d,%0d want 14,28,42", rv_t[0], rv_t[1], rv_t[2]);
    end
    total++; if (!ch_ok) begin bad++; $display("FAIL cont_result: got a report not ch3/0 want ch3/0"); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle: got busy=%0b want 0", busy); end
  endtask

  task automatic test_abort();
    bit seen;
    int n;
    start_sweep(4'b0010, 12'd16, 16'd0);
    wait_rv(60, seen, n);
    total++; if (!seen || result !== 16'd0 || result_ch !== 2'd1) begin
      bad++; $display("FAIL abort_setup: got seen=%0b res=%0d ch=%0d want 1/0/1", seen, result, result_ch);
    end
    repeat (2) tick();
    per[2] = 8;
    start_sweep(4'b0100, 12'd16, 16'd0);
    repeat (14) tick();
    total++; if (busy !== 1'b1 || osc_en !== 4'b0100) begin
      bad++; $display("FAIL abort_counting: got busy=%0b osc_en=%0h want 1/4", busy, osc_en);
    end
    ena = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || osc_en !== 4'h0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL abort_idle: got busy=%0b osc_en=%0h rv=%0b want 0/0/0", busy, osc_en, result_valid);
    end
    total++; if (result !== 16'd0 || result_ch !== 2'd1 || alarm_flags !== 4'b0101) begin
      bad++; $display("FAIL abort_retain: got res=%0d ch=%0d flags=%0h want 0/1/5", result, result_ch, alarm_flags);
    end
    ena = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_no_restart: got %0b want 0", busy); end
    per[2] = 0;
  endtask

  task automatic test_reset_mid();
    per[0] = 4;
    start_sweep(4'b0001, 12'd16, 16'd0);
    repeat (14) tick();
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || osc_en !== 4'h0 || result_valid !== 1'b0) begin
      bad++; $display("FAIL rst_mid_ctrl: got busy=%0b osc_en=%0h rv=%0b want 0/0/0", busy, osc_en, result_valid);
    end
    total++; if (result !== 16'd0 || result_ch !== 2'd0 || alarm_flags !== 4'h0 || alarm !== 1'b0) begin
      bad++; $display("FAIL rst_mid_data: got res=%0d ch=%0d flags=%0h want 0/0/0", result, result_ch, alarm_flags);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    per[0] = 0;
  endtask

  task automatic test_window_zero();
    per[0] = 4;
    start_sweep(4'b0001, 12'd0, 16'd0);
    for (int t = 2; t <= 11; t++) begin
      tick();
      if (t == 10) begin
        total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL win0_early: got rv=1 want 0"); end
      end
    end
    total++; if (result_valid !== 1'b1 || result > 16'd1 || result_ch !== 2'd0) begin
      bad++; $display("FAIL win0_report: got rv=%0b res=%0d ch=%0d want 1/<=1/0", result_valid, result, result_ch);
    end
    repeat (2) tick();
  endtask

  task automatic test_saturate();
    bit seen;
    int n;
    start_sweep(4'b0001, 12'd100, 16'd0);
    wait_rv(130, seen, n);
    total++; if (!seen || n != 109) begin bad++; $display("FAIL sat_latency: got seen=%0b n=%0d want 1/109", seen, n); end
    total++; if (result_valid_s !== 1'b1 || result_s !== 4'hF) begin
      bad++; $display("FAIL sat_value: got rv=%0b res=%0h want 1/f", result_valid_s, result_s);
    end
    total++; if (!(result >= 16'd24 && result <= 16'd26)) begin
      bad++; $display("FAIL sat_wide_count: got %0d want 24..26", result);
    end
    repeat (2) tick();
    per[0] = 0;
  endtask

  task automatic test_alarm();
    bit seen;
    int n;
    start_sweep(4'b0010, 12'd16, 16'd5);
    wait_rv(60, seen, n);
    total++; if (!seen || alarm_flags !== 4'b0010 || alarm !== 1'b1) begin
      bad++; $display("FAIL alarm_set: got seen=%0b flags=%0h alarm=%0b want 1/2/1", seen, alarm_flags, alarm);
    end
    repeat (2) tick();
    per[1] = 4;
    start_sweep(4'b0010, 12'd16, 16'd3);
    wait_rv(60, seen, n);
    total++; if (!seen || !(result >= 16'd3 && result <= 16'd5)) begin
      bad++; $display("FAIL alarm_high_count: got seen=%0b res=%0d want 1/3..5", seen, result);
    end
`ifdef STRESS_SENSOR_ALARM_LATCH_EN
    total++; if (alarm_flags !== 4'b0010 || alarm !== 1'b1) begin
      bad++; $display("FAIL alarm_sticky: got flags=%0h alarm=%0b want 2/1", alarm_flags, alarm);
    end
    repeat (2) tick();
    clear_alarm = 1'b1;
    tick();
    clear_alarm = 1'b0;
    total++; if (alarm_flags !== 4'h0 || alarm !== 1'b0) begin
      bad++; $display("FAIL alarm_clear: got flags=%0h alarm=%0b want 0/0", alarm_flags, alarm);
    end
`else
    total++; if (alarm_flags !== 4'h0 || alarm !== 1'b0) begin
      bad++; $display("FAIL alarm_overwrite: got flags=%0h alarm=%0b want 0/0", alarm_flags, alarm);
    end
`endif
    per[1] = 0;
    repeat (2) tick();
  endtask

  initial begin
    ena = 1'b0; start = 1'b0; continuous = 1'b0;
    ch_mask = '0; window_len = '0; thresh = '0; thresh_s = '0;
    test_reset();
    test_sweep();
    test_mask_zero();
    test_continuous();
    test_abort();
    test_reset_mid();
    test_window_zero();
    test_saturate();
    test_alarm();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish before 200us");
    $fatal(1);
  end

endmodule
